// File: rtl/imu_spi_pkg.sv
// Shared definitions for the IMU SPI arbiter: FSM encoding, requester indices and
// IMU register addresses. The watchdog feature is selected by IMU_SPI_ARB_WDT_EN.
package imu_spi_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_OWN  = 2'd1;
  localparam arb_state_t ARB_XFER = 2'd2;
  localparam arb_state_t ARB_GAP  = 2'd3;

  localparam int unsigned REQ_SENSOR = 0;
  localparam int unsigned REQ_CFG    = 1;

  // IMU register map (subset) and the read flag OR-ed into the address byte.
  localparam logic [7:0] IMU_READ     = 8'h80;
  localparam logic [7:0] SMPLRT_DIV   = 8'h19;
  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] WHO_AM_I     = 8'h75;

  function automatic logic [7:0] imu_rd(input logic [7:0] reg_addr);
    return reg_addr | IMU_READ;
  endfunction

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/imu_spi_arbiter_if.sv
// Requester-side and spi_master-side bus of the IMU SPI arbiter.
// master: the arbiter itself; slave: the surrounding requesters and spi_master.
interface imu_spi_arbiter_if;
  logic [1:0] req;
  logic [1:0] start;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [1:0] gnt;
  logic [1:0] fin;
  logic [7:0] rx_data;
  logic       m_start;
  logic [7:0] m_addr;
  logic       m_busy;
  logic       m_finish;
  logic [7:0] m_data;

  modport master (
    input  req, start, addr0, addr1, m_busy, m_finish, m_data,
    output gnt, fin, rx_data, m_start, m_addr
  );

  modport slave (
    output req, start, addr0, addr1, m_busy, m_finish, m_data,
    input  gnt, fin, rx_data, m_start, m_addr
  );
endinterface

// File: rtl/imu_spi_arb_timer.sv
// Loadable saturating down-counter, shared by the SS gap countdown and the
// owner watchdog (the two never run at the same time).
module imu_spi_arb_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_dec,
  output logic [Width-1:0] o_count
);

  logic [Width-1:0] r_count;

  // Load has priority over decrement; the count sticks at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/imu_spi_arbiter.sv
// Two-requester arbiter for one byte-level SPI master and the IMU chip select.
// An owner keeps SS low for a multi-byte burst; after release SS stays high for
// SS_GAP cycles before the next grant. Define IMU_SPI_ARB_WDT_EN to enable the
// idle-owner watchdog (WDT_CYCLES) and the sticky wdt_trip flag.
module imu_spi_arbiter
  import imu_spi_pkg::*;
#(
  parameter int unsigned PRIO_FIXED = 0,
  parameter int unsigned SS_GAP     = 4,
  parameter int unsigned WDT_CYCLES = 4096
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  imu_spi_arbiter_if.master      io_bus,
  output logic                   o_spi_ss,
  output logic                   o_wdt_trip
);

  localparam int unsigned TimerMax = (WDT_CYCLES > SS_GAP) ? WDT_CYCLES : SS_GAP;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  arb_state_t  r_state, w_state_nxt;
  logic        r_owner, w_owner_nxt;
  logic        r_last_owner, w_last_nxt;
  logic [1:0]  r_gnt, w_gnt_nxt;
  logic        r_ss, w_ss_nxt;
  logic        r_m_start, w_m_start_nxt;
  logic [7:0]  r_m_addr, w_m_addr_nxt;
  logic [7:0]  r_rx_data, w_rx_nxt;

  logic [1:0]        w_block;
  logic [1:0]        w_req_eff;
  logic              w_pick;
  logic              w_owner_req;
  logic              w_owner_start;
  logic              w_release;
  logic              w_finish_now;
  logic              w_tmr_load;
  logic [TimerW-1:0] w_tmr_val;
  logic              w_tmr_dec;
  logic [TimerW-1:0] w_tmr_count;

`ifdef IMU_SPI_ARB_WDT_EN
  logic       w_wdt_fire;
  logic       r_wdt_trip;
  logic [1:0] r_wdt_block;
  assign w_block = r_wdt_block;
`else
  assign w_block = 2'b00;
`endif

  assign w_req_eff     = io_bus.req & ~w_block;
  assign w_owner_req   = io_bus.req[r_owner];
  assign w_owner_start = io_bus.start[r_owner];
  assign w_finish_now  = (r_state == ARB_XFER) && io_bus.m_finish;

  // Choose the next owner: a lone requester wins; ties go by priority or round-robin.
  always_comb begin
    w_pick = 1'b0;
    unique case (w_req_eff)
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = (PRIO_FIXED != 0) ? 1'b0 : ~r_last_owner;
      default: w_pick = 1'b0;
    endcase
  end

  // Next-state logic for the ownership FSM and its registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last_owner;
    w_gnt_nxt     = r_gnt;
    w_ss_nxt      = r_ss;
    w_m_start_nxt = 1'b0;
    w_m_addr_nxt  = r_m_addr;
    w_rx_nxt      = r_rx_data;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_tmr_dec     = 1'b0;
    w_release     = 1'b0;
`ifdef IMU_SPI_ARB_WDT_EN
    w_wdt_fire    = 1'b0;
`endif
    unique case (r_state)
      ARB_IDLE: begin
        // A start seen in this cycle is deliberately not carried into OWN.
        if (|w_req_eff) begin
          w_owner_nxt = w_pick;
          w_gnt_nxt   = onehot2(w_pick);
          w_ss_nxt    = 1'b0;
          w_state_nxt = ARB_OWN;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TimerW'(WDT_CYCLES);
        end
      end
      ARB_OWN: begin
        if (!w_owner_req) begin
          w_release = 1'b1;
        end else if (w_owner_start && !io_bus.m_busy) begin
          w_m_start_nxt = 1'b1;
          w_m_addr_nxt  = r_owner ? io_bus.addr1 : io_bus.addr0;
          w_state_nxt   = ARB_XFER;
        end
`ifdef IMU_SPI_ARB_WDT_EN
        // Count reloads to WDT_CYCLES on each grant/byte; the last idle cycle trips.
        else if (w_tmr_count <= TimerW'(1)) begin
          w_release  = 1'b1;
          w_wdt_fire = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
`endif
      end
      ARB_XFER: begin
        // Owner's req is ignored here, so a mid-byte release waits for finish.
        if (io_bus.m_finish) begin
          w_rx_nxt    = io_bus.m_data;
          w_state_nxt = ARB_OWN;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TimerW'(WDT_CYCLES);
        end
      end
      ARB_GAP: begin
        // The IDLE cycle that follows is the last SS-high cycle before a grant.
        if (w_tmr_count <= TimerW'(1)) begin
          w_state_nxt = ARB_IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase

    if (w_release) begin
      w_gnt_nxt   = 2'b00;
      w_ss_nxt    = 1'b1;
      w_last_nxt  = r_owner;
      w_tmr_load  = 1'b1;
      w_tmr_val   = TimerW'(SS_GAP - 1);
      w_state_nxt = (SS_GAP > 1) ? ARB_GAP : ARB_IDLE;
    end
  end

  // Arbiter state and registered outputs; rst returns everything to idle values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_gnt        <= 2'b00;
      r_ss         <= 1'b1;
      r_m_start    <= 1'b0;
      r_m_addr     <= 8'hFF;
      r_rx_data    <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_gnt        <= w_gnt_nxt;
      r_ss         <= w_ss_nxt;
      r_m_start    <= w_m_start_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_rx_data    <= w_rx_nxt;
    end
  end

`ifdef IMU_SPI_ARB_WDT_EN
  // Sticky trip flag; a timed-out requester is blocked until its req drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wdt_trip  <= 1'b0;
      r_wdt_block <= 2'b00;
    end else begin
      if (w_wdt_fire) begin
        r_wdt_trip <= 1'b1;
      end
      r_wdt_block <= (r_wdt_block & io_bus.req) | (w_wdt_fire ? onehot2(r_owner) : 2'b00);
    end
  end
  assign o_wdt_trip = r_wdt_trip;
`else
  assign o_wdt_trip = 1'b0;
`endif

  imu_spi_arb_timer #(
    .Width (TimerW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_count    (w_tmr_count)
  );

  assign io_bus.gnt     = r_gnt;
  assign io_bus.fin     = w_finish_now ? onehot2(r_owner) : 2'b00;
  assign io_bus.rx_data = w_finish_now ? io_bus.m_data : r_rx_data;
  assign io_bus.m_start = r_m_start;
  assign io_bus.m_addr  = r_m_addr;
  assign o_spi_ss       = r_ss;

endmodule
